// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with sequential/redirect next-PC and a BOOT/RUN/TRAP/HALT FSM.
// Latency: pc, fetch_valid, misalign, epc and state are registered (1 cycle); pc_plus4 and target are combinational.
// Backpressure: pc holds while fetch_ready=0 in RUN; halt_req freezes fetch until resume.
// Build option: define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets (default: targets force-aligned).

module pc_gen #(
    parameter int             N            = 32,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter logic [N-1:0]   TRAP_VECTOR  = 'h100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_ready,
    input  logic          branch_taken,
    input  logic          jal,
    input  logic          jalr,
    input  logic [N-1:0]  imm_out,
    input  logic [N-1:0]  rs1_data,
    input  logic          halt_req,
    input  logic          resume,
    output logic [N-1:0]  pc,
    output logic [N-1:0]  pc_plus4,
    output logic [N-1:0]  target,
    output logic          fetch_valid,
    output logic          misalign,
    output logic [N-1:0]  epc,
    output logic [1:0]    state
);

    // Encodings are visible on the state port, so they are fixed.
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    // Sequential step size, and masks for JALR bit-0 clearing and word alignment.
    localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};
    localparam logic [N-1:0] JALR_MASK  = ~{{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ALIGN_MASK = ~{{(N-2){1'b0}}, 2'b11};

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   epc_q, epc_d;
    logic           fetch_valid_q, fetch_valid_d;
    logic           misalign_q, misalign_d;

    logic [N-1:0]   seq_sum;
    logic [N-1:0]   pc_rel_sum;
    logic [N-1:0]   reg_rel_sum;
    logic [N-1:0]   target_raw;
    logic [N-1:0]   target_w;
    logic           redirect;
    logic           misaligned;

    // All adders are plain N-bit and wrap silently; no carry is kept.
    assign seq_sum     = pc_q + PC_STEP;
    assign pc_rel_sum  = pc_q + imm_out;
    assign reg_rel_sum = rs1_data + imm_out;

    // JALR wins the target source; JAL and a taken branch share pc+imm.
    assign target_raw  = jalr ? (reg_rel_sum & JALR_MASK) : pc_rel_sum;

`ifdef PC_MISALIGN_TRAP_EN
    // Target is exposed as computed so a misaligned value can be detected.
    assign target_w    = target_raw;
`else
    // Without trapping, the low two bits are dropped so the PC can never go misaligned.
    assign target_w    = target_raw & ALIGN_MASK;
`endif

    assign redirect    = jalr | jal | branch_taken;
    assign misaligned  = redirect & (target_w[1:0] != 2'b00);

    // Next-state, next-PC and trap capture; RUN items are resolved in priority order.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    // Any redirect presented alongside halt is dropped; upstream re-presents it.
                    state_d = ST_HALT;
                end else if (!fetch_ready) begin
                    // Instruction memory stalled: hold everything, ignore control inputs.
                    state_d = ST_RUN;
                end else if (TRAP_EN && misaligned) begin
                    epc_d      = pc_q;
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                    state_d    = ST_TRAP;
                end else if (redirect) begin
                    pc_d = target_w;
                end else begin
                    pc_d = seq_sum;
                end
            end
            ST_TRAP: begin
                // One bubble while pc sits on the trap vector.
                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // fetch_valid is registered, so it is derived from where the FSM is heading.
        fetch_valid_d = (state_d == ST_RUN);
    end

    // State and datapath registers; reset restores the boot values immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = seq_sum;
    assign target      = target_w;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = misalign_q;
    assign epc         = epc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Each vector is driven just after a rising edge; the monitor samples on the following falling edge.
// Expected values cover both builds of the misaligned-trap option.

module tb_pc_gen;

    localparam int N = 32;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [1:0] B = 2'b00, R = 2'b01, T = 2'b10, H = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic          jal = 1'b0;
    logic          jalr = 1'b0;
    logic [N-1:0]  imm_out = '0;
    logic [N-1:0]  rs1_data = '0;
    logic          halt_req = 1'b0;
    logic          resume = 1'b0;
    logic [N-1:0]  pc;
    logic [N-1:0]  pc_plus4;
    logic [N-1:0]  target;
    logic          fetch_valid;
    logic          misalign;
    logic [N-1:0]  epc;
    logic [1:0]    state;

    always #5 clk = ~clk;

    pc_gen #(
        .N            (N),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_ready  (fetch_ready),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .imm_out      (imm_out),
        .rs1_data     (rs1_data),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .target       (target),
        .fetch_valid  (fetch_valid),
        .misalign     (misalign),
        .epc          (epc),
        .state        (state)
    );

    typedef struct {
        int           id;
        logic [31:0]  pc;
        logic         fv;
        logic [1:0]   st;
        logic         mis;
        logic [31:0]  epc;
        logic         chk_tgt;
        logic [31:0]  tgt;
    } exp_t;

    exp_t  sbq[$];
    exp_t  mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    vid = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL v%0d %s: got %h want %h", id, nm, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must look like during that cycle.
    task automatic vec(input logic r, input logic fr, input logic br, input logic j, input logic jr,
                       input logic h, input logic rs, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] e_pc, input logic e_fv, input logic [1:0] e_st,
                       input logic e_mis, input logic [31:0] e_epc, input logic ct,
                       input logic [31:0] e_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = r;
        fetch_ready  = fr;
        branch_taken = br;
        jal          = j;
        jalr         = jr;
        halt_req     = h;
        resume       = rs;
        imm_out      = imm;
        rs1_data     = rs1;
        e.id      = vid;
        e.pc      = e_pc;
        e.fv      = e_fv;
        e.st      = e_st;
        e.mis     = e_mis;
        e.epc     = e_epc;
        e.chk_tgt = ct;
        e.tgt     = e_tgt;
        sbq.push_back(e);
        vid++;
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("pc",          mon_e.id, pc,                 mon_e.pc);
                chk("pc_plus4",    mon_e.id, pc_plus4,           mon_e.pc + 32'd4);
                chk("fetch_valid", mon_e.id, {31'd0, fetch_valid}, {31'd0, mon_e.fv});
                chk("state",       mon_e.id, {30'd0, state},     {30'd0, mon_e.st});
                chk("misalign",    mon_e.id, {31'd0, misalign},  {31'd0, mon_e.mis});
                chk("epc",         mon_e.id, epc,                mon_e.epc);
                if (mon_e.chk_tgt) begin
                    chk("target",  mon_e.id, target,             mon_e.tgt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //   r  fr br j  jr h  rs imm            rs1            exp pc                             fv  st  mis          epc                                tgt?  tgt
        // Reset held, then released: one BOOT cycle, then sequential fetch 0,4,8.
        vec(0, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     0,  B,  0,           32'h0,                             1, 32'h0000_0000);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     0,  B,  0,           32'h0,                             0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     1,  R,  0,           32'h0,                             0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004,                     1,  R,  0,           32'h0,                             0, 32'h0);
        // JAL to 0x100.
        vec(1, 1, 0, 1, 0, 0, 0, 32'h0000_00F8,  32'h0,         32'h0000_0008,                     1,  R,  0,           32'h0,                             1, 32'h0000_0100);
        // Taken branch -40 stalled by fetch_ready=0, then accepted.
        vec(1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFD8,  32'h0,         32'h0000_0100,                     1,  R,  0,           32'h0,                             1, 32'h0000_00D8);
        vec(1, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFD8,  32'h0,         32'h0000_0100,                     1,  R,  0,           32'h0,                             1, 32'h0000_00D8);
        // JAL to 0x200.
        vec(1, 1, 0, 1, 0, 0, 0, 32'h0000_0128,  32'h0,         32'h0000_00D8,                     1,  R,  0,           32'h0,                             1, 32'h0000_0200);
        // JALR to 0x1002: trap to 0x100 or force-aligned to 0x1000.
        vec(1, 1, 0, 0, 1, 0, 0, 32'h0000_0002,  32'h0000_1001, 32'h0000_0200,                     1,  R,  0,           32'h0,                             1, TRAP ? 32'h0000_1002 : 32'h0000_1000);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         TRAP ? 32'h0000_0100 : 32'h0000_1000, !TRAP, TRAP ? T : R, TRAP, TRAP ? 32'h0000_0200 : 32'h0, 0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         TRAP ? 32'h0000_0100 : 32'h0000_1004, 1, R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      0, 32'h0);
        // JALR to absolute 0x40 rejoins both builds.
        vec(1, 1, 0, 0, 1, 0, 0, 32'h0,          32'h0000_0040, TRAP ? 32'h0000_0104 : 32'h0000_1008, 1, R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, 32'h0000_0040);
        // JAL and branch together -> 0x50; then JALR beats JAL -> 0xFFFF_FFFC.
        vec(1, 1, 1, 1, 0, 0, 0, 32'h0000_0010,  32'h0,         32'h0000_0040,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, 32'h0000_0050);
        vec(1, 1, 0, 1, 1, 0, 0, 32'h0000_000C,  32'hFFFF_FFF0, 32'h0000_0050,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, 32'hFFFF_FFFC);
        // Sequential step from 0xFFFF_FFFC wraps to 0.
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, 32'hFFFF_FFFC);
        // Halt together with JAL: halt wins, JAL dropped; halt_req ignored in HALT; resume.
        vec(1, 1, 0, 1, 0, 1, 0, 32'h0000_0020,  32'h0,         32'h0000_0000,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, 32'h0000_0020);
        vec(1, 1, 0, 1, 0, 1, 0, 32'h0000_0020,  32'h0,         32'h0000_0000,                     0,  H,  0,           TRAP ? 32'h0000_0200 : 32'h0,      0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 1, 32'h0,          32'h0,         32'h0000_0000,                     0,  H,  0,           TRAP ? 32'h0000_0200 : 32'h0,      0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      0, 32'h0);
        // JAL to 0xA: traps (epc=8) when enabled, else lands on 0x8.
        vec(1, 1, 0, 1, 0, 0, 0, 32'h0000_0002,  32'h0,         32'h0000_0008,                     1,  R,  0,           TRAP ? 32'h0000_0200 : 32'h0,      1, TRAP ? 32'h0000_000A : 32'h0000_0008);
        // Reset during the following cycle (TRAP when enabled): reset values appear at once.
        vec(0, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     0,  B,  0,           32'h0,                             0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     0,  B,  0,           32'h0,                             0, 32'h0);
        vec(1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000,                     1,  R,  0,           32'h0,                             0, 32'h0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
